rr_fifo_arbiter: RTL and testbench
==================================

// Module: rr_fifo_arbiter
// PURPOSE
//  Downstream consumer of four parallel data FIFOs (one per virtual channel).
//  Round-robin pops non-empty FIFOs, re-times the returned words and pushes
//  them into a single output FIFO.
//  Stalls on output almost_full/full so no word is ever dropped.
// PARAMETERS
//  DATA_WIDTH   10  word width, equal to the upstream FIFOs' data_width
//  RD_LATENCY    2  cycles from pop high (registered) to valid fifo_data_in word
//  CNT_WIDTH     8  width of the pushed-word counter
// PORTS
//  clk              in   1             single clock, all logic on posedge
//  reset            in   1             asynchronous, active-low
//  fifo_empty       in   4             empty flag per input FIFO
//  fifo_almost_empty in  4             almost_empty flag per input FIFO
//  fifo_data_in     in   4*DATA_WIDTH  FIFO i word at [i*DATA_WIDTH +: DATA_WIDTH]
//  out_almost_full  in   1             output FIFO almost_full
//  out_full         in   1             output FIFO full
//  pop              out  4             one-hot pop to input FIFOs
//  push_out         out  1             push to output FIFO
//  data_out         out  DATA_WIDTH    word to output FIFO
//  grant            out  2             index of last FIFO popped
//  idle_out         out  1             high in IDLE with no pops in flight
//  word_count       out  CNT_WIDTH     words pushed since reset, wraps
// BEHAVIOUR
//  Reset (reset==0, async): pop=0, push_out=0, data_out=0, grant=3, idle_out=1,
//   word_count=0, in-flight pipe cleared, FSM=IDLE.
//   Asserting reset mid-operation discards all in-flight words.
//  FSM states and transitions:
//   IDLE:   all fifo_empty=1 -> stay; any non-empty and no stall -> ACTIVE;
//           any non-empty and stall -> PAUSE
//   ACTIVE: stall -> PAUSE; all empty (after masking) -> IDLE
//   PAUSE:  stall=0 -> ACTIVE if a candidate exists, else IDLE
//   stall = out_almost_full | out_full
//  Pop rules (pop is a registered output):
//   - At most one pop bit per cycle; pop is issued only in ACTIVE.
//   - Candidate i requires fifo_empty[i]==0 and mask[i]==0.
//   - Search starts at grant+1 mod 4 and wraps. Winner drives pop[i] next cycle
//     and grant<=i. No candidate -> pop=0, grant unchanged.
//   - If fifo_almost_empty[winner]==1 at the pop decision, mask[winner]=1 for the
//     next RD_LATENCY cycles. This covers the flag lag so an empty FIFO is never
//     popped.
//  Return path:
//   - Shift register of depth RD_LATENCY carries {valid, index} per pop.
//   - When its tail is valid, sample fifo_data_in[index]. Next cycle
//     push_out=1, data_out=that word, word_count+=1 (mod 2^CNT_WIDTH).
//   - Pop-to-push latency = RD_LATENCY+1 cycles.
//   - Otherwise push_out=0 and data_out holds its last value.
//   - In-flight words still push while stalled; the output almost_full margin
//     must be >= RD_LATENCY+1.
//  idle_out = (state==IDLE) & no valid entry in the pipe.
// TESTING
//  1. Reset low, then release with all FIFOs empty -> pop=0, push_out=0,
//     idle_out=1, grant=3.
//  2. FIFOs 0..3 each hold one word (0x001,0x002,0x003,0x004) ->
//     pops 0,1,2,3 on consecutive cycles; pushes 0x001..0x004 with 3-cycle
//     latency; word_count=4.
//  3. Only FIFO 2 non-empty with 5 words, almost_empty high on the last ->
//     pop[2] never issued while fifo_empty[2]=1; exactly 5 pushes.
//  4. out_almost_full rises after the 2nd pop -> pop=0 next cycle, FSM=PAUSE,
//     in-flight words still pushed; resumes at next RR index when flag drops.
//  5. Reset asserted mid-stream with 2 words in flight -> outputs go to reset
//     values immediately; no push follows.
//  6. Push 2^CNT_WIDTH+3 words -> word_count wraps to 3.

Source files
------------

// File: rtl/rr_fifo_arbiter.sv
// rr_fifo_arbiter: round-robin drain of four virtual-channel FIFOs into one
// output FIFO; pops are registered and returned words re-timed in pop order.
module rr_fifo_arbiter #(
   parameter int DATA_WIDTH = 10,
   parameter int RD_LATENCY = 2,
   parameter int CNT_WIDTH  = 8
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [3:0]              fifo_empty,
   input  logic [3:0]              fifo_almost_empty,
   input  logic [4*DATA_WIDTH-1:0] fifo_data_in,
   input  logic                    out_almost_full,
   input  logic                    out_full,
   output logic [3:0]              pop,
   output logic                    push_out,
   output logic [DATA_WIDTH-1:0]   data_out,
   output logic [1:0]              grant,
   output logic                    idle_out,
   output logic [CNT_WIDTH-1:0]    word_count
);

   localparam int MW = $clog2(RD_LATENCY + 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      PAUSE  = 2'd2
   } state_t;

   state_t                state_q;
   logic [3:0]            pop_q;
   logic [1:0]            grant_q;
   logic [MW-1:0]         mask_cnt_q [4];

   logic [RD_LATENCY-1:0] pv_q;
   logic [RD_LATENCY-1:0] pv_d;
   logic [1:0]            pidx_q [RD_LATENCY];
   logic [1:0]            pidx_d [RD_LATENCY];

   logic                  push_q;
   logic                  push_d;
   logic [DATA_WIDTH-1:0] data_q;
   logic [DATA_WIDTH-1:0] data_d;
   logic [CNT_WIDTH-1:0]  cnt_q;
   logic [CNT_WIDTH-1:0]  cnt_d;

   logic                  stall;
   logic [3:0]            mask;
   logic [3:0]            cand;
   logic                  win_found;
   logic [1:0]            win_idx;
   logic [DATA_WIDTH-1:0] words [4];
   logic                  tail_v;
   logic [1:0]            tail_idx;

   assign stall = out_almost_full | out_full;

   always_comb begin
      mask = '0;
      for (int i = 0; i < 4; i++) begin
         mask[i]  = (mask_cnt_q[i] != '0);
         words[i] = fifo_data_in[i*DATA_WIDTH +: DATA_WIDTH];
      end
      cand = ~fifo_empty & ~mask;
   end

   // Search starts one past the last grant; k==4 revisits grant itself last.
   always_comb begin
      logic [1:0] idx;
      win_found = 1'b0;
      win_idx   = grant_q;
      idx       = grant_q;
      for (int k = 1; k <= 4; k++) begin
         idx = grant_q + 2'(k);
         if (!win_found && cand[idx]) begin
            win_found = 1'b1;
            win_idx   = idx;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         pop_q   <= '0;
         grant_q <= 2'd3;
         for (int i = 0; i < 4; i++) begin
            mask_cnt_q[i] <= '0;
         end
      end else begin
         pop_q <= '0;
         for (int i = 0; i < 4; i++) begin
            if (mask_cnt_q[i] != '0) begin
               mask_cnt_q[i] <= mask_cnt_q[i] - MW'(1);
            end
         end
         unique case (state_q)
            IDLE: begin
               if (fifo_empty != 4'hf) begin
                  state_q <= stall ? PAUSE : ACTIVE;
               end
            end
            ACTIVE: begin
               if (stall) begin
                  state_q <= PAUSE;
               end else if (!win_found) begin
                  state_q <= IDLE;
               end else begin
                  pop_q   <= 4'b0001 << win_idx;
                  grant_q <= win_idx;
                  // Hide the flag lag of a FIFO about to run dry.
                  if (fifo_almost_empty[win_idx]) begin
                     mask_cnt_q[win_idx] <= MW'(RD_LATENCY);
                  end
               end
            end
            PAUSE: begin
               if (!stall) begin
                  state_q <= win_found ? ACTIVE : IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   always_comb begin
      pv_d      = '0;
      pv_d[0]   = |pop_q;
      pidx_d[0] = grant_q;
      for (int k = 1; k < RD_LATENCY; k++) begin
         pv_d[k]   = pv_q[k-1];
         pidx_d[k] = pidx_q[k-1];
      end
   end

   assign tail_v   = pv_q[RD_LATENCY-1];
   assign tail_idx = pidx_q[RD_LATENCY-1];

   always_comb begin
      push_d = tail_v;
      data_d = tail_v ? words[tail_idx] : data_q;
      cnt_d  = cnt_q + CNT_WIDTH'(tail_v);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pv_q   <= '0;
         push_q <= 1'b0;
         data_q <= '0;
         cnt_q  <= '0;
         for (int k = 0; k < RD_LATENCY; k++) begin
            pidx_q[k] <= '0;
         end
      end else begin
         pv_q   <= pv_d;
         push_q <= push_d;
         data_q <= data_d;
         cnt_q  <= cnt_d;
         for (int k = 0; k < RD_LATENCY; k++) begin
            pidx_q[k] <= pidx_d[k];
         end
      end
   end

   assign pop        = pop_q;
   assign grant      = grant_q;
   assign push_out   = push_q;
   assign data_out   = data_q;
   assign word_count = cnt_q;
   assign idle_out   = (state_q == IDLE) && (pv_q == '0);

endmodule

// File: tb/tb_rr_fifo_arbiter.sv
// tb_rr_fifo_arbiter: queue-based upstream FIFO model plus a scoreboard of
// expected pushes (word and due cycle) checked by an independent monitor.
module tb_rr_fifo_arbiter;

   localparam int DW  = 10;
   localparam int RDL = 2;
   localparam int CW  = 8;
   localparam int N6  = (1 << CW) + 3;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic [3:0]    fifo_empty;
   logic [3:0]    fifo_almost_empty;
   logic [4*DW-1:0] fifo_data_in;
   logic          out_almost_full = 1'b0;
   logic          out_full = 1'b0;
   logic [3:0]    pop;
   logic          push_out;
   logic [DW-1:0] data_out;
   logic [1:0]    grant;
   logic          idle_out;
   logic [CW-1:0] word_count;

   rr_fifo_arbiter #(
      .DATA_WIDTH(DW),
      .RD_LATENCY(RDL),
      .CNT_WIDTH (CW)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .fifo_empty       (fifo_empty),
      .fifo_almost_empty(fifo_almost_empty),
      .fifo_data_in     (fifo_data_in),
      .out_almost_full  (out_almost_full),
      .out_full         (out_full),
      .pop              (pop),
      .push_out         (push_out),
      .data_out         (data_out),
      .grant            (grant),
      .idle_out         (idle_out),
      .word_count       (word_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [DW-1:0] word;
      int            due;
   } exp_t;

   exp_t          expq[$];
   logic [DW-1:0] srcq [4][$];
   logic [DW-1:0] rd1 [4];
   int            pop_log[$];
   int            pop_cyc[$];
   int            cyc = 0;
   int            n_chk = 0;
   int            n_fail = 0;
   int            wc_model = 0;
   bit            stall_prev = 1'b0;

   function automatic void chk(input string name,
                               input logic [63:0] got,
                               input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                  name, got, exp, cyc);
      end
   endfunction

   function automatic int logat(input int n);
      return (n < pop_log.size()) ? pop_log[n] : -1;
   endfunction

   function automatic bit src_all_empty();
      return srcq[0].size() == 0 && srcq[1].size() == 0 &&
             srcq[2].size() == 0 && srcq[3].size() == 0;
   endfunction

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Upstream FIFOs: pop seen at an edge removes the head; the word shows on
   // fifo_data_in two cycles after pop went high. Flags follow the count,
   // with almost_empty raised at two words or fewer.
   initial begin
      logic [3:0] p;
      int         pc;
      exp_t       e;
      fifo_empty        = 4'hf;
      fifo_almost_empty = 4'hf;
      fifo_data_in      = '0;
      for (int i = 0; i < 4; i++) rd1[i] = '0;
      forever begin
         @(negedge clk);
         p  = pop;
         pc = cyc;
         @(posedge clk);
         #1;
         for (int i = 0; i < 4; i++) begin
            fifo_data_in[i*DW +: DW] = rd1[i];
            if (p[i] && srcq[i].size() > 0) begin
               rd1[i] = srcq[i].pop_front();
               e.word = rd1[i];
               e.due  = pc + RDL + 1;
               expq.push_back(e);
            end
         end
         for (int i = 0; i < 4; i++) begin
            fifo_empty[i]        = (srcq[i].size() == 0);
            fifo_almost_empty[i] = (srcq[i].size() <= 2);
         end
      end
   end

   // Monitor: pop legality and the push scoreboard.
   initial begin
      exp_t e;
      int   idx;
      forever begin
         @(negedge clk);
         #2;
         if (!reset) begin
            stall_prev = 1'b0;
         end else begin
            if (stall_prev) chk("pop_while_stalled", pop, 0);
            if (pop != 4'h0) begin
               chk("pop_onehot", $countones(pop), 1);
               chk("pop_on_empty", pop & fifo_empty, 0);
               chk("grant_tracks_pop", pop, 4'b0001 << grant);
               idx = 0;
               for (int i = 0; i < 4; i++) if (pop[i]) idx = i;
               pop_log.push_back(idx);
               pop_cyc.push_back(cyc);
            end
            stall_prev = out_almost_full | out_full;
            if (push_out) begin
               if (expq.size() == 0) begin
                  chk("unexpected_push", 1, 0);
               end else begin
                  e = expq.pop_front();
                  wc_model++;
                  chk("push_data", data_out, e.word);
                  chk("push_latency", cyc, e.due);
                  chk("word_count", word_count, wc_model % (1 << CW));
               end
            end
         end
      end
   end

   task automatic wait_drain(input int budget, input string name);
      int n;
      n = 0;
      while (!(src_all_empty() && expq.size() == 0 && idle_out === 1'b1)
             && n < budget) begin
         @(posedge clk);
         #3;
         n++;
      end
      chk(name, n < budget, 1);
      repeat (3) @(posedge clk);
      #3;
   endtask

   task automatic wait_pops(input int n_want, output int n_got);
      int t;
      n_got = 0;
      t = 0;
      while (n_got < n_want && t < 60) begin
         @(negedge clk);
         #1;
         if (pop != 4'h0) n_got++;
         t++;
      end
   endtask

   initial begin
      int base;
      int n;
      int loaded;
      int t;

      // Reset state, then release with all FIFOs empty.
      repeat (3) @(posedge clk);
      #1;
      chk("rst_pop", pop, 0);
      chk("rst_push", push_out, 0);
      chk("rst_grant", grant, 3);
      chk("rst_idle", idle_out, 1);
      chk("rst_data", data_out, 0);
      chk("rst_wc", word_count, 0);
      @(posedge clk);
      #3;
      reset = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      chk("t1_pop", pop, 0);
      chk("t1_push", push_out, 0);
      chk("t1_idle", idle_out, 1);
      chk("t1_grant", grant, 3);

      // One word in each FIFO.
      #2;
      base = pop_log.size();
      for (int k = 0; k < 4; k++) srcq[k].push_back(DW'(k + 1));
      wait_drain(100, "t2_drain");
      chk("t2_npops", pop_log.size() - base, 4);
      for (int k = 0; k < 4; k++) chk("t2_pop_order", logat(base + k), k);
      if (pop_log.size() >= base + 4)
         chk("t2_consecutive", pop_cyc[base+3] - pop_cyc[base], 3);
      chk("t2_wc", word_count, 4);

      // Five words in FIFO 2 only.
      base = pop_log.size();
      for (int k = 0; k < 5; k++) srcq[2].push_back(DW'(10'h100 + k));
      wait_drain(100, "t3_drain");
      chk("t3_npops", pop_log.size() - base, 5);
      for (int k = 0; k < 5; k++) chk("t3_pop_idx", logat(base + k), 2);
      chk("t3_wc", word_count, 9);

      // Stall after the second pop, then resume at the next index.
      base = pop_log.size();
      for (int i = 0; i < 4; i++)
         for (int k = 0; k < 4; k++)
            srcq[i].push_back(DW'(10'h200 + 16 * i + k));
      wait_pops(2, n);
      out_almost_full = 1'b1;
      chk("t4_two_pops", n, 2);
      @(negedge clk);
      #1;
      chk("t4_pause_pop", pop, 0);
      chk("t4_pause_idle", idle_out, 0);
      repeat (6) @(posedge clk);
      #3;
      chk("t4_no_pop_paused", pop_log.size() - base, 2);
      chk("t4_inflight_pushed", expq.size(), 0);
      out_almost_full = 1'b0;
      wait_drain(200, "t4_drain");
      chk("t4_first", logat(base), 3);
      chk("t4_second", logat(base + 1), 0);
      chk("t4_resume", logat(base + 2), 1);
      chk("t4_wc", word_count, 9 + 16);

      // Reset with words in flight.
      for (int i = 0; i < 4; i++)
         for (int k = 0; k < 3; k++)
            srcq[i].push_back(DW'(10'h300 + 16 * i + k));
      wait_pops(2, n);
      chk("t5_two_pops", n, 2);
      reset = 1'b0;
      #1;
      chk("t5_pop", pop, 0);
      chk("t5_push", push_out, 0);
      chk("t5_data", data_out, 0);
      chk("t5_grant", grant, 3);
      chk("t5_idle", idle_out, 1);
      chk("t5_wc", word_count, 0);
      repeat (3) @(posedge clk);
      #3;
      for (int i = 0; i < 4; i++) srcq[i].delete();
      expq.delete();
      wc_model = 0;
      @(posedge clk);
      #3;
      reset = 1'b1;
      repeat (10) @(posedge clk);
      #3;
      chk("t5_no_push_after", word_count, 0);

      // Random traffic and stalls until the counter wraps.
      loaded = 0;
      t = 0;
      while (loaded < N6 && t < 5000) begin
         @(posedge clk);
         #3;
         t++;
         if ($urandom_range(0, 1) == 1) begin
            srcq[$urandom_range(0, 3)].push_back(DW'($urandom_range(0, 1023)));
            loaded++;
         end
         out_almost_full = ($urandom_range(0, 7) == 0);
         out_full        = ($urandom_range(0, 15) == 0);
      end
      out_almost_full = 1'b0;
      out_full        = 1'b0;
      chk("t6_loaded", loaded, N6);
      wait_drain(3000, "t6_drain");
      chk("t6_pushes", wc_model, N6);
      chk("t6_wc_wrap", word_count, N6 % (1 << CW));

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout");
      $fatal(1, "watchdog");
   end

endmodule
